// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM states and a divide-op decode helper.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] FN_MUL    = 3'b000;
  localparam logic [2:0] FN_MULH   = 3'b001;
  localparam logic [2:0] FN_MULHSU = 3'b010;
  localparam logic [2:0] FN_MULHU  = 3'b011;
  localparam logic [2:0] FN_DIV    = 3'b100;
  localparam logic [2:0] FN_DIVU   = 3'b101;
  localparam logic [2:0] FN_REM    = 3'b110;
  localparam logic [2:0] FN_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic is_div(input logic [2:0] fn);
    return fn[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the issuing stage and the mul/div unit.
interface muldiv_if #(parameter int XLEN = 32);

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            wb_en;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in,
    input  busy, done, result, rd_out, wb_en
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in,
    output busy, done, result, rd_out, wb_en
  );

endinterface

// File: rtl/muldiv_special_detect.sv
// Combinational decode of divide-by-zero and signed-overflow operands,
// together with the architecturally defined result for each case.
module muldiv_special_detect
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_special,
  output logic [XLEN-1:0] o_value
);

  logic w_div_zero;
  logic w_overflow;

  assign w_div_zero = is_div(i_funct3) && (i_rs2 == '0);
  assign w_overflow = ((i_funct3 == FN_DIV) || (i_funct3 == FN_REM)) &&
                      (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
  assign o_special  = w_div_zero | w_overflow;

  // funct3[1] separates remainder ops from quotient ops.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    o_value = '0;
    if (w_div_zero)
      o_value = i_funct3[1] ? i_rs1 : '1;
    else if (w_overflow)
      o_value = i_funct3[1] ? '0 : i_rs1;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: shift-add multiply / restoring divide over
// XLEN cycles, sign fix-up, then a one-cycle write-back strobe.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(XLEN);

  state_t            r_state;
  logic [2:0]        r_fn;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_a, r_b, r_quo, r_rem, r_result, r_forced;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_neg, r_special, r_busy, r_done, r_wb_en;

  logic              w_signed_a, w_signed_b, w_sign_a, w_sign_b;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_forced, w_fixed, w_quo_f, w_rem_f;
  logic              w_special;
  logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_diff;
  logic              w_div_ok;
  logic [2*XLEN-1:0] w_prod;

  muldiv_special_detect #(.XLEN(XLEN)) u_special (
    .i_funct3  (bus.funct3),
    .i_rs1     (bus.rs1_val),
    .i_rs2     (bus.rs2_val),
    .o_special (w_special),
    .o_value   (w_forced)
  );

  // MUL returns only the low half, which is sign-agnostic, so it runs unsigned.
  assign w_signed_a = (bus.funct3 == FN_MULH) || (bus.funct3 == FN_MULHSU) ||
                      (bus.funct3 == FN_DIV)  || (bus.funct3 == FN_REM);
  assign w_signed_b = (bus.funct3 == FN_MULH) || (bus.funct3 == FN_DIV) ||
                      (bus.funct3 == FN_REM);
  assign w_sign_a   = w_signed_a & bus.rs1_val[XLEN-1];
  assign w_sign_b   = w_signed_b & bus.rs2_val[XLEN-1];
  assign w_mag_a    = w_sign_a ? -bus.rs1_val : bus.rs1_val;
  assign w_mag_b    = w_sign_b ? -bus.rs2_val : bus.rs2_val;

  // Multiplier sits in the low half of r_acc and is consumed LSB-first.
  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_div_shift = {r_rem, r_quo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_ok    = ~w_div_diff[XLEN];

  assign w_prod  = r_neg ? -r_acc : r_acc;
  assign w_quo_f = r_neg ? -r_quo : r_quo;
  assign w_rem_f = r_neg ? -r_rem : r_rem;

  always_comb begin
    w_fixed = w_prod[2*XLEN-1:XLEN];
    case (r_fn)
      FN_MUL:          w_fixed = w_prod[XLEN-1:0];
      FN_DIV, FN_DIVU: w_fixed = w_quo_f;
      FN_REM, FN_REMU: w_fixed = w_rem_f;
      default:         w_fixed = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_fn      <= '0;
      r_rd      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_forced  <= '0;
      r_neg     <= 1'b0;
      r_special <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wb_en   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done  <= 1'b0;
          r_wb_en <= 1'b0;
          if (bus.start) begin
            r_fn      <= bus.funct3;
            r_rd      <= bus.rd_in;
            r_a       <= w_mag_a;
            r_b       <= w_mag_b;
            r_quo     <= w_mag_a;
            r_rem     <= '0;
            r_acc     <= {{XLEN{1'b0}}, w_mag_b};
            r_cnt     <= '0;
            r_neg     <= (bus.funct3 == FN_REM) ? w_sign_a : (w_sign_a ^ w_sign_b);
            r_special <= w_special;
            r_forced  <= w_forced;
            r_busy    <= 1'b1;
            r_state   <= w_special ? ST_FIX : ST_CALC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (is_div(r_fn)) begin
            r_rem <= w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_div_ok};
          end else begin
            r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN-1))
            r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_result <= r_special ? r_forced : w_fixed;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_wb_en  <= (r_rd != 5'd0);
          r_state  <= ST_DONE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.rd_out = r_rd;
  assign bus.wb_en  = r_wb_en;

endmodule
